base_level_seq: RTL and testbench

//  Per-coefficient-group sequencer for the CABAC rate estimator. Accepts absolute levels in

---
 rtl/base_level_seq.sv | 178 +++++++++++++++++
 tb/tb_base_level_seq.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/base_level_seq.sv
// Per-coefficient-group sequencer: tracks c1Idx/c2Idx, drives base_level_calc, emits baseLevel/remainder.
// Optional escape remainder on out_rem is enabled by defining BLS_REM_EN (otherwise tied to zero).
module base_level_seq #(
    parameter int LEVEL_W = 16,
    parameter int CG_SIZE = 16,
    parameter int C1_MAX  = 8,
    parameter int C2_MAX  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cg_start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LEVEL_W-1:0] in_abs,
    input  logic               in_last,
    output logic               calc_start,
    output logic [7:0]         calc_c1Idx,
    output logic [7:0]         calc_c2Idx,
    input  logic [7:0]         calc_baseLevel,
    input  logic               calc_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_base,
    output logic [LEVEL_W-1:0] out_rem,
    output logic               out_last,
    output logic [3:0]         out_idx,
    output logic               busy,
    output logic               err_overrun
);

    localparam int IDX_W = $clog2(CG_SIZE + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [LEVEL_W-1:0] abs_q;
    logic               last_q;
    logic [7:0]         base_q;
    logic [7:0]         c1_idx;
    logic [7:0]         c2_idx;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_inc;
    logic               err_q;

    logic accept;
    logic out_hs;
    logic calc_hit;
    logic abs_nz;
    logic c1_inc;
    logic c2_inc;
    logic wrap_cg;
    logic cg_clear;

    assign accept   = in_valid && (state == S_IDLE);
    assign out_hs   = out_ready && (state == S_OUT);
    assign calc_hit = calc_done && (state == S_WAIT);
    assign abs_nz   = (abs_q != '0);

    // greater2 only advances while greater1 flags are still being coded
    assign c1_inc  = abs_nz && (c1_idx < 8'(C1_MAX));
    assign c2_inc  = c1_inc && (abs_q > LEVEL_W'(1)) && (c2_idx < 8'(C2_MAX));
    assign idx_inc = idx + IDX_W'(1);

    assign wrap_cg  = out_hs && !last_q && (idx_inc == IDX_W'(CG_SIZE));
    assign cg_clear = ((state == S_IDLE) && cg_start) || (out_hs && last_q) || wrap_cg;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nxt = (in_abs != '0) ? S_ISSUE : S_OUT;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (calc_done) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cg_start in IDLE takes effect in the same edge as an accept, so the
    // accepted coefficient is issued with cleared counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1_idx <= '0;
            c2_idx <= '0;
            idx    <= '0;
        end else if (cg_clear) begin
            c1_idx <= '0;
            c2_idx <= '0;
            idx    <= '0;
        end else if (out_hs) begin
            if (c1_inc) begin
                c1_idx <= c1_idx + 8'd1;
            end
            if (c2_inc) begin
                c2_idx <= c2_idx + 8'd1;
            end
            idx <= idx_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (wrap_cg) begin
            err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs_q  <= '0;
            last_q <= 1'b0;
            base_q <= '0;
        end else if (accept) begin
            abs_q  <= in_abs;
            last_q <= in_last;
            base_q <= '0;
        end else if (calc_hit) begin
            base_q <= calc_baseLevel;
        end
    end

`ifdef BLS_REM_EN
    logic [LEVEL_W-1:0] rem_q;
    logic [LEVEL_W-1:0] base_ext;

    assign base_ext = LEVEL_W'(calc_baseLevel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
        end else if (accept) begin
            rem_q <= '0;
        end else if (calc_hit) begin
            rem_q <= (abs_q >= base_ext) ? (abs_q - base_ext) : '0;
        end
    end

    assign out_rem = rem_q;
`else
    assign out_rem = '0;
`endif

    assign in_ready    = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign calc_start  = (state == S_ISSUE);
    assign calc_c1Idx  = c1_idx;
    assign calc_c2Idx  = c2_idx;
    assign out_valid   = (state == S_OUT);
    assign out_base    = base_q;
    assign out_last    = last_q;
    assign out_idx     = 4'(idx);
    assign err_overrun = err_q;

endmodule

// File: tb/tb_base_level_seq.sv
// Scoreboarded random + directed bench for base_level_seq with a behavioural base_level_calc stand-in.
module tb_base_level_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cg_start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_abs = '0;
    logic        in_last = 1'b0;
    logic        calc_start;
    logic [7:0]  calc_c1Idx;
    logic [7:0]  calc_c2Idx;
    logic [7:0]  calc_baseLevel = '0;
    logic        calc_done = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_base;
    logic [15:0] out_rem;
    logic        out_last;
    logic [3:0]  out_idx;
    logic        busy;
    logic        err_overrun;

    always #5 clk = ~clk;

    base_level_seq dut (
        .clk(clk), .rst_n(rst_n), .cg_start(cg_start), .in_valid(in_valid), .in_ready(in_ready),
        .in_abs(in_abs), .in_last(in_last), .calc_start(calc_start), .calc_c1Idx(calc_c1Idx),
        .calc_c2Idx(calc_c2Idx), .calc_baseLevel(calc_baseLevel), .calc_done(calc_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_base(out_base), .out_rem(out_rem),
        .out_last(out_last), .out_idx(out_idx), .busy(busy), .err_overrun(err_overrun)
    );

    typedef struct packed {
        logic [7:0]  base;
        logic [15:0] rem;
        logic        last;
        logic [3:0]  idx;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] calc_q[$];
    int          n_pass = 0;
    int          n_chk = 0;

    int m_c1 = 0, m_c2 = 0, m_idx = 0;
    bit m_err = 1'b0;

    int lat_min = 1, lat_max = 1;
    int rdy_pct = 100;
    bit rdy_hold = 1'b0;
    bit spur_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Stand-in for base_level_calc: 1 once greater1 flags are exhausted, else 2 + (greater2 flag left)
    function automatic int calc_model(input int c1, input int c2);
        if (c1 >= 8) return 1;
        return (c2 < 1) ? 3 : 2;
    endfunction

    function automatic void model_clear();
        m_c1 = 0; m_c2 = 0; m_idx = 0;
    endfunction

    function automatic void model_accept(input logic [15:0] a, input bit last, input bit cgs);
        exp_t e;
        int   ai = int'(a);
        int   b;
        if (cgs) model_clear();
        if (ai == 0) b = 0;
        else begin
            b = calc_model(m_c1, m_c2);
            calc_q.push_back({8'(m_c1), 8'(m_c2)});
        end
        e.base = 8'(b);
`ifdef BLS_REM_EN
        e.rem = (ai >= b) ? 16'(ai - b) : 16'd0;
`else
        e.rem = 16'd0;
`endif
        e.last = last;
        e.idx  = 4'(m_idx);
        exp_q.push_back(e);
        if (ai != 0 && m_c1 < 8) begin
            m_c1++;
            if (ai > 1 && m_c2 < 1) m_c2++;
        end
        if (last) model_clear();
        else begin
            m_idx++;
            if (m_idx == 16) begin
                model_clear();
                m_err = 1'b1;
            end
        end
    endfunction

    // calc responder: checks issued counters, answers after a random latency, injects stray done pulses in IDLE
    initial begin
        int          cnt = 0;
        logic [7:0]  pend = '0;
        logic [15:0] e;
        forever begin
            @(posedge clk); #1;
            calc_done = 1'b0;
            if (!rst_n) cnt = 0;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    calc_done = 1'b1;
                    calc_baseLevel = pend;
                end
            end else if (spur_en && !busy && $urandom_range(3) == 0) begin
                calc_done = 1'b1;
                calc_baseLevel = 8'($urandom);
            end
            @(negedge clk);
            if (rst_n && calc_start) begin
                if (calc_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL calc_unexpected: got calc_start expected none at %0t", $time);
                end else begin
                    e = calc_q.pop_front();
                    check("calc_c1Idx", {24'd0, calc_c1Idx}, {24'd0, e[15:8]});
                    check("calc_c2Idx", {24'd0, calc_c2Idx}, {24'd0, e[7:0]});
                end
                pend = 8'(calc_model(int'(calc_c1Idx), int'(calc_c2Idx)));
                cnt  = $urandom_range(lat_max, lat_min);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = !rdy_hold && ($urandom_range(99) < rdy_pct);
        end
    end

    // output monitor: pops the scoreboard on each handshake and checks hold-while-stalled
    initial begin
        logic [28:0] prev = '0;
        bit          have_prev = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (have_prev) check("out_stable", {3'd0, out_base, out_rem, out_last, out_idx}, {3'd0, prev});
                check("in_ready_in_out", {31'd0, in_ready}, 32'd0);
                if (out_ready) begin
                    have_prev = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL out_unexpected: got out_base %0d expected no output at %0t", out_base, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_base", {24'd0, out_base}, {24'd0, e.base});
                        check("out_rem", {16'd0, out_rem}, {16'd0, e.rem});
                        check("out_last", {31'd0, out_last}, {31'd0, e.last});
                        check("out_idx", {28'd0, out_idx}, {28'd0, e.idx});
                    end
                end else begin
                    prev = {out_base, out_rem, out_last, out_idx};
                    have_prev = 1'b1;
                end
            end else have_prev = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [15:0] a, input bit last, input bit cgs);
        int to = 0;
        bit ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_abs = a; in_last = last; cg_start = cgs;
        while (to < 200) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            to++;
        end
        if (ok) model_accept(a, last, cgs);
        else begin
            n_chk++;
            $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0; cg_start = 1'b0;
    endtask

    task automatic drain();
        int to = 0;
        while ((exp_q.size() != 0 || busy) && to < 500) begin
            @(negedge clk);
            to++;
        end
        if (to >= 500) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic measure(output int t_start, output int t_valid);
        t_start = -1;
        t_valid = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (calc_start && t_start < 0) t_start = n;
            if (out_valid) begin t_valid = n; break; end
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_ctrl"}, {26'd0, in_ready, out_valid, busy, calc_start, err_overrun, out_last},
              32'b100000);
        check({name, "_data"}, {out_base, out_rem, 4'd0, out_idx}, 32'd0);
        check({name, "_cidx"}, {16'd0, calc_c1Idx, calc_c2Idx}, 32'd0);
    endtask

    function automatic logic [15:0] rand_abs();
        int r = $urandom_range(9);
        if (r <= 2) return 16'd0;
        if (r <= 5) return 16'd1;
        if (r == 6) return 16'd2;
        if (r == 7) return 16'd3;
        if (r == 8) return 16'($urandom_range(20, 4));
        return 16'($urandom);
    endfunction

    initial begin
        int ts, tv;
        logic [15:0] cg_a[4] = '{16'd1, 16'd1, 16'd2, 16'd3};

        repeat (3) @(posedge clk);
        #1 check_reset_state("reset");
        @(negedge clk) rst_n = 1'b1;

        // latency with a 1-cycle calc: nonzero and zero coefficient
        send(16'd5, 1'b0, 1'b1);
        measure(ts, tv);
        check("lat_calc_start", ts, 32'd1);
        check("lat_out_nonzero", tv, 32'd3);
        drain();
        send(16'd0, 1'b0, 1'b0);
        measure(ts, tv);
        check("lat_calc_start_zero", ts, 32'hFFFF_FFFF);
        check("lat_out_zero", tv, 32'd1);
        drain();
        send(16'd3, 1'b1, 1'b0);
        drain();

        for (int k = 0; k < 4; k++) send(cg_a[k], k == 3, k == 0);
        drain();
        for (int k = 0; k < 9; k++) send(16'd1, k == 8, k == 0);
        drain();

        // back-pressure with a slow calc
        lat_min = 4; lat_max = 4; rdy_hold = 1'b1;
        send(16'd7, 1'b1, 1'b1);
        for (int n = 0; n < 30 && !out_valid; n++) @(negedge clk);
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", {30'd0, in_ready, out_valid}, 32'b01);
        end
        rdy_hold = 1'b0;
        drain();

        lat_min = 1; lat_max = 4; rdy_pct = 70; spur_en = 1'b1;
        for (int g = 0; g < 40; g++) begin
            int len = $urandom_range(16, 1);
            bit cgs = 1'($urandom_range(1));
            for (int k = 0; k < len; k++) send(rand_abs(), k == len - 1, (k == 0) && cgs);
        end
        drain();
        check("err_after_random", {31'd0, err_overrun}, {31'd0, m_err});

        // 16 coefficients without in_last
        for (int k = 0; k < 15; k++) send(16'd1, 1'b0, k == 0);
        drain();
        check("err_before_16", {31'd0, err_overrun}, {31'd0, m_err});
        send(16'd2, 1'b0, 1'b0);
        drain();
        check("err_after_16", {31'd0, err_overrun}, {31'd0, m_err});
        send(16'd2, 1'b0, 1'b0);
        send(16'd1, 1'b1, 1'b0);
        drain();
        check("err_sticky", {31'd0, err_overrun}, {31'd0, m_err});

        // reset while waiting on a slow calc
        spur_en = 1'b0; rdy_pct = 100; lat_min = 8; lat_max = 8;
        send(16'd2, 1'b0, 1'b1);
        drain();
        send(16'd1, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("wait_before_reset", {30'd0, busy, calc_start}, 32'b10);
        rst_n = 1'b0;
        #1 check_reset_state("reset_mid");
        exp_q.delete();
        calc_q.delete();
        model_clear();
        m_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        lat_min = 1; lat_max = 1;
        send(16'd1, 1'b0, 1'b0);
        send(16'd4, 1'b1, 1'b0);
        drain();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("calc_queue_empty", calc_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
